alu_seq_param: RTL and testbench
================================

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept request.
REQ-006 SHALL have ports: a, b  input  WIDTH  operands.
REQ-007 SHALL have ports: cin, ainvert, bnegate  input  1 each  carry-in, invert a, invert b.
REQ-008 SHALL have port: op  input  2  00 AND, 01 OR, 10 ADD, 11 MUL.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have ports: cout, zero, overflow, illegal  output  1 each  status flags.

Function
REQ-013 SHALL form A' = ainvert ? ~a : a and B' = bnegate ? ~b : b for AND/OR/ADD.
REQ-014 SHALL compute AND = A'&B', OR = A'|B', ADD = A'+B'+cin truncated to WIDTH; cout = carry out of bit WIDTH-1.
REQ-015 SHALL set overflow for ADD when A'[MSB]==B'[MSB] and result[MSB] differs; overflow = 0 for all other ops.
REQ-016 SHALL set zero = (result == 0) for every op, sampled with result.
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on clk edge with in_valid & in_ready, capturing all operands and controls.
REQ-019 SHALL, for AND/OR/ADD, go IDLE -> DONE with result registered; out_valid asserted the cycle after acceptance (latency 1).
REQ-020 SHALL, for MUL, go IDLE -> BUSY, run unsigned shift-add for exactly WIDTH cycles on raw a, b (ainvert, bnegate, cin ignored), then -> DONE; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-021 SHALL give MUL result = low WIDTH bits of a*b, cout = 1 iff high WIDTH bits nonzero.
REQ-022 SHALL hold result and all flags stable in DONE while out_ready = 0.
REQ-023 SHALL go DONE -> IDLE on out_valid & out_ready; out_valid drops the next cycle; no new request is accepted in that same cycle.
REQ-024 SHALL ignore in_valid and input changes while in BUSY or DONE.
REQ-025 SHALL keep illegal = 0 except as stated in REQ-030.

Reset
REQ-026 SHALL, on rst_n low, immediately enter IDLE and clear result, cout, zero, overflow, illegal, out_valid, and multiplier accumulator/counter; in_ready = 1 while in reset.
REQ-027 SHALL abandon any BUSY or DONE operation on reset; no out_valid for it after release.
REQ-028 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro ALU_SEQ_MUL_EN defined, include the iterative multiplier per REQ-020/021.
REQ-030 SHALL, without ALU_SEQ_MUL_EN, omit multiplier logic; op=11 goes IDLE -> DONE with latency 1, result = 0, zero = 1, cout = 0, illegal = 1.

Verification (WIDTH=16)
REQ-031 SHALL test ADD a=1001, b=1234, cin=0 -> result 2235, cout 0, zero 0, overflow 0, out_valid 1 cycle after accept.
REQ-032 SHALL test SUB (cin=1, bnegate=1) a=1001, b=1234 -> result 65303 (0xFF17), cout 0; a=1234, b=1001 -> result 233, cout 1.
REQ-033 SHALL test ADD a=0x7FFF, b=1 -> result 0x8000, overflow 1; AND a=1, b=1 -> 1; OR a=0, b=0 -> 0, zero 1.
REQ-034 SHALL test MUL a=300, b=300 with ALU_SEQ_MUL_EN -> result 24464, cout 1, out_valid exactly 17 cycles after accept, in_ready 0 throughout.
REQ-035 SHALL test backpressure: hold out_ready=0 for 5 cycles after DONE -> result/flags stable, in_ready 0; then out_ready=1 -> IDLE next cycle.
REQ-036 SHALL test rst_n pulsed low at cycle 8 of MUL -> all outputs 0 immediately, in_ready 1, no stale out_valid; without macro, op=11 -> illegal 1, result 0.

Source files
------------

// File: rtl/alu_seq_param.sv
// Handshaked sequential ALU: AND/OR/ADD in one cycle, optional iterative shift-add MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise op=11 reports illegal.
module alu_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic             accept, is_mul, ld_alu, mul_last;
  logic [WIDTH-1:0] ap, bp, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_cout, alu_ovf, alu_ill;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, zero_q, ovf_q, ill_q;

  assign accept = in_valid && (state_q == IDLE);
  assign is_mul = (op == 2'b11);
  assign ld_alu = accept && !(is_mul && MUL_EN);

  assign ap  = ainvert ? ~a : a;
  assign bp  = bnegate ? ~b : b;
  assign sum = {1'b0, ap} + {1'b0, bp} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (op)
      2'b00: alu_res = ap & bp;
      2'b01: alu_res = ap | bp;
      2'b10: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = (ap[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != ap[WIDTH-1]);
      end
      default: alu_ill = !MUL_EN;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  // One partial product per BUSY cycle, WIDTH cycles total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
`else
  assign mul_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (is_mul && MUL_EN) ? BUSY : DONE;
      BUSY: if (mul_last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else if (ld_alu) begin
      result_q <= alu_res;
      cout_q   <= alu_cout;
      zero_q   <= (alu_res == '0);
      ovf_q    <= alu_ovf;
      ill_q    <= alu_ill;
    end
`ifdef ALU_SEQ_MUL_EN
    else if ((state_q == BUSY) && mul_last) begin
      result_q <= acc_nxt[WIDTH-1:0];
      cout_q   <= |acc_nxt[2*WIDTH-1:WIDTH];
      zero_q   <= (acc_nxt[WIDTH-1:0] == '0);
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end
`endif
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed vector bench for alu_seq_param (WIDTH=16), both with and without ALU_SEQ_MUL_EN.
module tb_alu_seq_param;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, ainvert = 1'b0, bnegate = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         in_ready, out_valid, cout, zero, overflow, illegal;
  logic [W-1:0] result;

  int errors = 0, checks = 0;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .ainvert(ainvert), .bnegate(bnegate), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         cin, ainv, bneg;
    logic [W-1:0] res;
    logic         cout, zero, ovf, ill;
    int           lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input string nm);
    chk({nm, ".res"}, result, 0);
    chk({nm, ".flags"}, {cout, zero, overflow, illegal}, 0);
    chk({nm, ".ovld"}, out_valid, 0);
    chk({nm, ".irdy"}, in_ready, 1);
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic do_op(input vec_t v);
    int lat;
    bit rdy_bad;
    a = v.a; b = v.b; op = v.op; cin = v.cin; ainvert = v.ainv; bnegate = v.bneg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~v.a; b = 16'h5A5A; op = v.op ^ 2'b01; cin = ~v.cin;
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({v.nm, ".lat"}, lat, v.lat);
    chk({v.nm, ".busy_rdy"}, rdy_bad, 0);
    chk({v.nm, ".done_rdy"}, in_ready, 0);
    chk({v.nm, ".res"}, result, v.res);
    chk({v.nm, ".cout"}, cout, v.cout);
    chk({v.nm, ".zero"}, zero, v.zero);
    chk({v.nm, ".ovf"}, overflow, v.ovf);
    chk({v.nm, ".ill"}, illegal, v.ill);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.nm, ".drop"}, out_valid, 0);
    chk({v.nm, ".back_idle"}, in_ready, 1);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    //          nm      op     a        b        cin ai  bn  res      co  z   ov  il  lat
    tbl.push_back('{"add",   2'b10, 16'd1001, 16'd1234, 0, 0, 0, 16'd2235,  0, 0, 0, 0, 1});
    tbl.push_back('{"sub1",  2'b10, 16'd1001, 16'd1234, 1, 0, 1, 16'hFF17,  0, 0, 0, 0, 1});
    tbl.push_back('{"sub2",  2'b10, 16'd1234, 16'd1001, 1, 0, 1, 16'd233,   1, 0, 0, 0, 1});
    tbl.push_back('{"ovf",   2'b10, 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000,  0, 0, 1, 0, 1});
    tbl.push_back('{"and1",  2'b00, 16'h0001, 16'h0001, 0, 0, 0, 16'h0001,  0, 0, 0, 0, 1});
    tbl.push_back('{"or0",   2'b01, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000,  0, 1, 0, 0, 1});
    tbl.push_back('{"wrap",  2'b10, 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000,  1, 1, 0, 0, 1});
    tbl.push_back('{"negov", 2'b10, 16'h8000, 16'h8000, 0, 0, 0, 16'h0000,  1, 1, 1, 0, 1});
    tbl.push_back('{"andai", 2'b00, 16'h00FF, 16'h0F0F, 0, 1, 0, 16'h0F00,  0, 0, 0, 0, 1});
    tbl.push_back('{"orbn",  2'b01, 16'h1200, 16'hFFFF, 1, 0, 1, 16'h1200,  0, 0, 0, 0, 1});
    tbl.push_back('{"addai", 2'b10, 16'h0000, 16'h0005, 0, 1, 0, 16'h0004,  1, 0, 0, 0, 1});
`ifdef ALU_SEQ_MUL_EN
    tbl.push_back('{"mul300",2'b11, 16'd300,  16'd300,  1, 1, 1, 16'd24464, 1, 0, 0, 0, 17});
    tbl.push_back('{"mulmax",2'b11, 16'hFFFF, 16'hFFFF, 0, 0, 0, 16'h0001,  1, 0, 0, 0, 17});
    tbl.push_back('{"mul0",  2'b11, 16'h0000, 16'h1234, 0, 1, 0, 16'h0000,  0, 1, 0, 0, 17});
    tbl.push_back('{"mulsm", 2'b11, 16'd7,    16'd9,    0, 0, 0, 16'd63,    0, 0, 0, 0, 17});
`else
    tbl.push_back('{"ill",   2'b11, 16'd300,  16'd300,  1, 0, 0, 16'h0000,  0, 1, 0, 1, 1});
`endif
    tbl.push_back('{"after", 2'b00, 16'hF0F0, 16'hFF00, 0, 0, 0, 16'hF000,  0, 0, 0, 0, 1});

    #1;
    chk_idle_reset("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) do_op(tbl[i]);

    // Backpressure: hold DONE for 5 cycles while inputs churn.
    a = 16'h7FFF; b = 16'h0001; op = 2'b10; cin = 0; ainvert = 0; bnegate = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      a = 16'(k * 77); op = 2'(k); in_valid = 1'b1;
      chk("bp.ovld", out_valid, 1);
      chk("bp.irdy", in_ready, 0);
      chk("bp.res", result, 16'h8000);
      chk("bp.flags", {cout, zero, overflow, illegal}, 4'b0010);
      @(posedge clk); #1;
    end
    a = 16'h0001; b = 16'h0001; op = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp.release_ovld", out_valid, 0);
    chk("bp.release_irdy", in_ready, 1);
    @(posedge clk); #1;
    chk("bp.no_accept", out_valid, 0);

    // Reset mid-operation must abandon it.
`ifdef ALU_SEQ_MUL_EN
    a = 16'd300; b = 16'd300; op = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
    chk("rst.busy_pre", in_ready, 0);
`else
    a = 16'h7FFF; b = 16'h0001; op = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst.done_pre", out_valid, 1);
`endif
    rst_n = 1'b0;
    #1;
    chk_idle_reset("rst.async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      bit stale = 1'b0;
      for (int k = 0; k < 25; k++) begin
        if (out_valid || !in_ready) stale = 1'b1;
        @(posedge clk); #1;
      end
      chk("rst.no_stale", stale, 0);
    end
    chk_idle_reset("rst.after");

    // Request presented right at reset release is taken on the first edge.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '{"first", 2'b10, 16'd40000, 16'd30000, 1, 0, 0, 16'd4465, 1, 0, 0, 0, 1};
    do_op(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
